// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Main control FSM for a multicycle RV32I-subset datapath. It sequences fetch,
// decode, address generation, memory access, execute and write-back. It also
// generates the datapath mux selects, ALU function and immediate format.
//
// Ports
//   clk        : single clock, rising-edge
//   rst        : synchronous active-high reset
//   op         : opcode field of the instruction register
//   funct3     : IR[14:12]
//   funct7_5   : IR[30]
//   Zero       : ALU zero flag for the current cycle
//   mem_ready  : memory finishes the pending request this cycle
//   mem_req    : memory request, held until mem_ready
//   MemWrite   : the memory request is a write
//   AdrSrc     : memory address select (0 = PC, 1 = ALUOut)
//   IRWrite    : load IR and OldPC
//   PCWrite    : PC <= Result
//   RegWrite   : rd <= Result
//   ResultSrc  : 00 ALUOut, 01 read data, 10 ALUResult
//   ALUSrcA    : 00 PC, 01 OldPC, 10 latched rs1
//   ALUSrcB    : 00 latched rs2, 01 Imm, 10 constant 4
//   ALUControl : 000 add, 001 sub, 010 and, 011 or, 101 slt
//   ImmSrc     : 00 I, 01 S, 10 B, 11 J
//   illegal_op : one-cycle pulse on an unsupported opcode
//   state_o    : current state encoding, for debug
// ---------------------------------------------------------------------------
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR_ADR = 4'd11,
        JALR_PC  = 4'd12
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [2:0] exec_alu;

    // State register; reset wins over any pending memory handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Unused encodings 13-15 fall into the default and
    // recover to FETCH.
    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:    next_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_R:         next_state = EXECR;
                    OP_I:         next_state = EXECI;
                    OP_BR:        next_state = BRANCH;
                    OP_JAL:       next_state = JAL;
                    OP_JALR:      next_state = JALR_ADR;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR:   next_state = (op == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  next_state = mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: next_state = mem_ready ? FETCH : MEMWRITE;
            MEMWB:    next_state = FETCH;
            EXECR:    next_state = ALUWB;
            EXECI:    next_state = ALUWB;
            ALUWB:    next_state = FETCH;
            BRANCH:   next_state = FETCH;
            JAL:      next_state = ALUWB;
            JALR_ADR: next_state = JALR_PC;
            JALR_PC:  next_state = ALUWB;
            default:  next_state = FETCH;
        endcase
    end

    // ALU function for R/I execution. Only R-type (op[5]=1) can select sub.
    // For I-type, IR[30] is part of the immediate.
    always_comb begin
        exec_alu = ALU_ADD;
        case (funct3)
            3'b000:  exec_alu = (op[5] & funct7_5) ? ALU_SUB : ALU_ADD;
            3'b010:  exec_alu = ALU_SLT;
            3'b110:  exec_alu = ALU_OR;
            3'b111:  exec_alu = ALU_AND;
            default: exec_alu = ALU_ADD;
        endcase
    end

    // Immediate format depends only on the opcode, in every state.
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BR:   ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Per-state outputs. While reset is high, every strobe that can change
    // architectural or memory state is masked off.
    always_comb begin
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        illegal_op = 1'b0;
        case (state)
            FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR:
                        illegal_op = 1'b0;
                    default:
                        illegal_op = 1'b1;
                endcase
            end
            MEMADR, JALR_ADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            MEMWRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            EXECR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b00;
                ALUControl = exec_alu;
            end
            EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = exec_alu;
            end
            ALUWB: begin
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b00;
                ALUControl = ALU_SUB;
                PCWrite    = ((funct3 == 3'b000) & Zero) |
                             ((funct3 == 3'b001) & ~Zero);
            end
            JAL, JALR_PC: begin
                PCWrite = 1'b1;
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
        if (rst) begin
            mem_req    = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Scoreboard bench for multicycle_ctrl. The stimulus side walks whole
// instructions cycle by cycle. For each cycle it pushes the expected state
// and outputs, built from a per-instruction-class phase model. A monitor pops
// and compares those entries on the falling edge.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       Zero;
    logic       mem_ready;
    logic       mem_req;
    logic       MemWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] ImmSrc;
    logic       illegal_op;
    logic [3:0] state_o;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctl;
        logic [1:0] imm_src;
        logic       illegal;
    } rec_t;

    typedef enum int {K_R, K_I, K_LW, K_SW, K_BR, K_JAL, K_JALR, K_ILL} kind_t;

    rec_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cycle_no    = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .illegal_op (illegal_op),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [6:0] op_of(kind_t k);
        logic [6:0] bad [4];
        bad[0] = 7'b0110111;
        bad[1] = 7'b0010111;
        bad[2] = 7'b1110011;
        bad[3] = 7'b0000000;
        case (k)
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_LW:    return 7'b0000011;
            K_SW:    return 7'b0100011;
            K_BR:    return 7'b1100011;
            K_JAL:   return 7'b1101111;
            K_JALR:  return 7'b1100111;
            default: return bad[$urandom_range(0, 3)];
        endcase
    endfunction

    function automatic logic [1:0] imm_of(logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] alu_of(kind_t k, logic [2:0] f3, logic f7);
        case (f3)
            3'b000:  return (k == K_R && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic rec_t base(int st, logic [6:0] o);
        rec_t r;
        r         = '0;
        r.st      = 4'(st);
        r.imm_src = imm_of(o);
        return r;
    endfunction

    function automatic rec_t fetch_rec(logic [6:0] o, logic ready);
        rec_t r;
        r            = base(0, o);
        r.mem_req    = 1'b1;
        r.alu_src_b  = 2'b10;
        r.result_src = 2'b10;
        r.ir_write   = ready;
        r.pc_write   = ready;
        return r;
    endfunction

    function automatic rec_t mem_rec(int st, logic [6:0] o);
        rec_t r;
        r           = base(st, o);
        r.mem_req   = 1'b1;
        r.adr_src   = 1'b1;
        r.mem_write = (st == 5);
        return r;
    endfunction

    function automatic rec_t in_reset(rec_t r);
        rec_t m;
        m           = r;
        m.mem_req   = 1'b0;
        m.mem_write = 1'b0;
        m.ir_write  = 1'b0;
        m.pc_write  = 1'b0;
        m.reg_write = 1'b0;
        m.illegal   = 1'b0;
        return m;
    endfunction

    // ---------------- stimulus ----------------
    task automatic step(input rec_t e, input logic ready);
        mem_ready = ready;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input kind_t k, input logic [6:0] o,
                                 input logic [2:0] f3, input logic f7,
                                 input logic z, input int fw, input int mw);
        rec_t e;
        op       = o;
        funct3   = f3;
        funct7_5 = f7;
        Zero     = z;
        for (int i = 0; i < fw; i++) step(fetch_rec(o, 1'b0), 1'b0);
        step(fetch_rec(o, 1'b1), 1'b1);
        e           = base(1, o);
        e.alu_src_a = 2'b01;
        e.alu_src_b = 2'b01;
        e.illegal   = (k == K_ILL);
        step(e, 1'($urandom_range(0, 1)));
        case (k)
            K_R, K_I: begin
                e           = base((k == K_R) ? 6 : 7, o);
                e.alu_src_a = 2'b10;
                e.alu_src_b = (k == K_R) ? 2'b00 : 2'b01;
                e.alu_ctl   = alu_of(k, f3, f7);
                step(e, 1'($urandom_range(0, 1)));
            end
            K_LW, K_SW: begin
                e           = base(2, o);
                e.alu_src_a = 2'b10;
                e.alu_src_b = 2'b01;
                step(e, 1'($urandom_range(0, 1)));
                for (int i = 0; i < mw; i++) step(mem_rec((k == K_LW) ? 3 : 5, o), 1'b0);
                step(mem_rec((k == K_LW) ? 3 : 5, o), 1'b1);
                if (k == K_LW) begin
                    e            = base(4, o);
                    e.result_src = 2'b01;
                    e.reg_write  = 1'b1;
                    step(e, 1'($urandom_range(0, 1)));
                end
            end
            K_BR: begin
                e           = base(9, o);
                e.alu_src_a = 2'b10;
                e.alu_ctl   = 3'b001;
                e.pc_write  = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z);
                step(e, 1'($urandom_range(0, 1)));
            end
            K_JAL, K_JALR: begin
                if (k == K_JALR) begin
                    e           = base(11, o);
                    e.alu_src_a = 2'b10;
                    e.alu_src_b = 2'b01;
                    step(e, 1'($urandom_range(0, 1)));
                end
                e           = base((k == K_JAL) ? 10 : 12, o);
                e.pc_write  = 1'b1;
                e.alu_src_a = 2'b01;
                e.alu_src_b = 2'b10;
                step(e, 1'($urandom_range(0, 1)));
            end
            default: begin
            end
        endcase
        // R, I, jal and jalr all finish in ALU write-back.
        if (k == K_R || k == K_I || k == K_JAL || k == K_JALR) begin
            e           = base(8, o);
            e.reg_write = 1'b1;
            step(e, 1'($urandom_range(0, 1)));
        end
    endtask

    // ---------------- monitor ----------------
    task automatic checkOutput(input rec_t e);
        rec_t a;
        a = '{st: state_o, mem_req: mem_req, mem_write: MemWrite, adr_src: AdrSrc,
              ir_write: IRWrite, pc_write: PCWrite, reg_write: RegWrite,
              result_src: ResultSrc, alu_src_a: ALUSrcA, alu_src_b: ALUSrcB,
              alu_ctl: ALUControl, imm_src: ImmSrc, illegal: illegal_op};
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("[TB] FAIL cycle%0d outputs: got st=%0d req=%b mw=%b adr=%b ir=%b pc=%b rw=%b rs=%b a=%b b=%b alu=%b imm=%b ill=%b, expected st=%0d req=%b mw=%b adr=%b ir=%b pc=%b rw=%b rs=%b a=%b b=%b alu=%b imm=%b ill=%b",
                     cycle_no, a.st, a.mem_req, a.mem_write, a.adr_src, a.ir_write, a.pc_write,
                     a.reg_write, a.result_src, a.alu_src_a, a.alu_src_b, a.alu_ctl, a.imm_src, a.illegal,
                     e.st, e.mem_req, e.mem_write, e.adr_src, e.ir_write, e.pc_write,
                     e.reg_write, e.result_src, e.alu_src_a, e.alu_src_b, e.alu_ctl, e.imm_src, e.illegal);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cycle_no++;
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        rec_t  e;
        kind_t k;
        rst       = 1'b1;
        op        = 7'b0110011;
        funct3    = 3'b000;
        funct7_5  = 1'b0;
        Zero      = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        // Reset held: FETCH selects visible, all strobes masked.
        step(in_reset(fetch_rec(op, 1'b1)), 1'b1);
        rst = 1'b0;

        applyStimulus(K_R,    op_of(K_R),    3'b000, 1'b0, 1'b0, 0, 0);  // add
        applyStimulus(K_R,    op_of(K_R),    3'b000, 1'b1, 1'b0, 0, 0);  // sub
        applyStimulus(K_I,    op_of(K_I),    3'b000, 1'b1, 1'b0, 0, 0);  // addi, IR[30]=1
        applyStimulus(K_R,    op_of(K_R),    3'b010, 1'b0, 1'b0, 0, 0);  // slt
        applyStimulus(K_I,    op_of(K_I),    3'b110, 1'b0, 1'b0, 0, 0);  // ori
        applyStimulus(K_R,    op_of(K_R),    3'b111, 1'b0, 1'b0, 0, 0);  // and
        applyStimulus(K_LW,   op_of(K_LW),   3'b010, 1'b0, 1'b0, 3, 2);  // lw with waits
        applyStimulus(K_SW,   op_of(K_SW),   3'b010, 1'b0, 1'b0, 0, 0);
        applyStimulus(K_BR,   op_of(K_BR),   3'b000, 1'b0, 1'b1, 0, 0);  // beq taken
        applyStimulus(K_BR,   op_of(K_BR),   3'b001, 1'b0, 1'b1, 0, 0);  // bne not taken
        applyStimulus(K_BR,   op_of(K_BR),   3'b001, 1'b0, 1'b0, 0, 0);  // bne taken
        applyStimulus(K_BR,   op_of(K_BR),   3'b100, 1'b0, 1'b1, 0, 0);  // blt never taken
        applyStimulus(K_JAL,  op_of(K_JAL),  3'b000, 1'b0, 1'b0, 0, 0);
        applyStimulus(K_JALR, op_of(K_JALR), 3'b000, 1'b0, 1'b0, 0, 0);
        applyStimulus(K_ILL,  7'b0110111,    3'b000, 1'b0, 1'b0, 0, 0);  // lui unsupported

        // Reset while MEMWRITE waits on memory.
        op       = op_of(K_SW);
        funct3   = 3'b010;
        funct7_5 = 1'b0;
        step(fetch_rec(op, 1'b1), 1'b1);
        e = base(1, op); e.alu_src_a = 2'b01; e.alu_src_b = 2'b01;
        step(e, 1'b0);
        e = base(2, op); e.alu_src_a = 2'b10; e.alu_src_b = 2'b01;
        step(e, 1'b0);
        step(mem_rec(5, op), 1'b0);
        rst = 1'b1;
        step(in_reset(mem_rec(5, op)), 1'b0);
        rst = 1'b0;
        // First cycle after reset must be a PC fetch.
        applyStimulus(K_R, op_of(K_R), 3'b000, 1'b0, 1'b0, 1, 0);

        for (int n = 0; n < 80; n++) begin
            k = kind_t'($urandom_range(0, 7));
            applyStimulus(k, op_of(k), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 op  input  7  opcode from instruction register (IR).
REQ-004 funct3  input  3  IR[14:12].
REQ-005 funct7_5  input  1  IR[30].
REQ-006 Zero  input  1  ALU zero flag, current cycle.
REQ-007 mem_ready  input  1  memory completes the pending request this cycle.
REQ-008 mem_req  output  1  memory access request; held until mem_ready.
REQ-009 MemWrite  output  1  request is a write.
REQ-010 AdrSrc  output  1  memory address: 0=PC, 1=ALUOut.
REQ-011 IRWrite  output  1  load IR and OldPC.
REQ-012 PCWrite  output  1  PC <= Result.
REQ-013 RegWrite  output  1  rd <= Result.
REQ-014 ResultSrc  output  2  00=ALUOut, 01=read data, 10=ALUResult.
REQ-015 ALUSrcA  output  2  00=PC, 01=OldPC, 10=latched rs1.
REQ-016 ALUSrcB  output  2  00=latched rs2, 01=Imm, 10=constant 4.
REQ-017 ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-018 ImmSrc  output  2  00 I, 01 S, 10 B, 11 J.
REQ-019 illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-020 state_o  output  4  current state encoding, for debug.

Function
REQ-021 State encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR_ADR=11, JALR_PC=12; codes 13-15 SHALL go to FETCH.
REQ-022 ImmSrc SHALL decode combinationally from op in every state:
- lw, I-ALU, jalr -> 00
- sw -> 01
- branch -> 10
- jal -> 11
- other -> 00
REQ-023 FETCH SHALL assert mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
- IRWrite and PCWrite SHALL assert only in the cycle mem_ready=1; the state then moves to DECODE.
- While mem_ready=0, the block SHALL stay in FETCH.
REQ-024 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, add (branch/jal target into ALUOut). Next state by op:
- 0000011 and 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BRANCH
- 1101111 -> JAL
- 1100111 -> JALR_ADR
- otherwise -> FETCH, with illegal_op=1 for that cycle
REQ-025 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, add; next state MEMREAD for lw, MEMWRITE for sw.
REQ-026 MEMREAD/MEMWRITE SHALL assert mem_req=1 and AdrSrc=1 (MemWrite=1 in MEMWRITE only) and hold until mem_ready=1.
- On mem_ready: MEMREAD -> MEMWB, MEMWRITE -> FETCH.
REQ-027 MEMWB SHALL assert ResultSrc=01 and RegWrite=1; next state FETCH.
REQ-028 EXECR (ALUSrcA=10, ALUSrcB=00) and EXECI (ALUSrcA=10, ALUSrcB=01) SHALL drive ALUControl by funct3:
- 000 -> sub when op[5]&funct7_5 = 1, else add
- 010 -> slt
- 110 -> or
- 111 -> and
- other -> add
- Next state ALUWB.
REQ-029 ALUWB SHALL assert ResultSrc=00 and RegWrite=1; next state FETCH.
REQ-030 BRANCH SHALL drive ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
- PCWrite = (funct3==000 & Zero) | (funct3==001 & ~Zero).
- Other funct3 values are never taken.
- Next state FETCH.
REQ-031 JAL SHALL assert PCWrite=1, ResultSrc=00, ALUSrcA=01, ALUSrcB=10, add (OldPC+4 into ALUOut); next state ALUWB.
REQ-032 JALR_ADR SHALL drive ALUSrcA=10, ALUSrcB=01, add; next state JALR_PC.
REQ-033 JALR_PC SHALL assert PCWrite=1, ResultSrc=00, ALUSrcA=01, ALUSrcB=10, add; next state ALUWB.
REQ-034 Outputs not listed for a state SHALL be 0, and mem_req SHALL never be asserted outside FETCH, MEMREAD and MEMWRITE.
REQ-035 Zero-wait cycle counts SHALL be: R/I 4, lw 5, sw 4, branch 3, jal 4, jalr 5.

Reset
REQ-036 When rst=1 at a clock edge, state SHALL become FETCH, regardless of the current state or a pending memory request.
REQ-037 While rst=1, mem_req, MemWrite, IRWrite, PCWrite, RegWrite and illegal_op SHALL be forced to 0.
REQ-038 In the first cycle after rst falls, the block SHALL assert mem_req=1 with AdrSrc=0.

Verification
REQ-039 add x3,x1,x2 (op=0110011, f3=000, f7_5=0), mem_ready=1 -> states 0,1,6,8; ALUControl=000 in EXECR; RegWrite=1 only in cycle 4.
REQ-040 sub (f7_5=1) vs addi with IR[30]=1 (op=0010011) -> ALUControl=001 vs 000.
REQ-041 lw with mem_ready low 3 cycles in FETCH and 2 in MEMREAD -> mem_req held, IRWrite single pulse, total 10 cycles, RegWrite with ResultSrc=01.
REQ-042 beq Zero=1 -> PCWrite=1 in BRANCH; bne Zero=1 -> PCWrite=0; funct3=100 -> PCWrite=0.
REQ-043 jalr -> states 0,1,11,12,8; PCWrite in state 12; RegWrite with ResultSrc=00 in ALUWB.
REQ-044 op=0110111 -> illegal_op pulse in DECODE, next FETCH; rst asserted in MEMWRITE with mem_ready=0 -> FETCH next cycle, MemWrite=0.
